// File: rtl/fifo_adapter_pkg.sv
// fifo_adapter_pkg: shared constants and helpers for the FIFO read adapter.
// Derives prefetch depth from read latency and sizes counters.
package fifo_adapter_pkg;

    localparam int c_LAT_MIN = 1;
    localparam int c_LAT_MAX = 2;

    function automatic int buf_depth(input int lat);
        return lat + 1;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// fifo_rd_stream_adapter_if: valid/ready stream bundle.
// The adapter is the master; the downstream sink is the slave.
interface fifo_rd_stream_adapter_if #(
    parameter int c_DATA_WIDTH = 32
);
    logic                    m_valid;
    logic                    m_ready;
    logic [c_DATA_WIDTH-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_prefetch_buf.sv
// fifo_rd_prefetch_buf: small circular register buffer with level count.
// Output word is held after the buffer drains so m_data stays stable.
module fifo_rd_prefetch_buf
    import fifo_adapter_pkg::*;
#(
    parameter int c_DATA_WIDTH = 32,
    parameter int c_DEPTH      = 2,
    parameter int c_LVL_WIDTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [c_DATA_WIDTH-1:0] wr_data,
    input  logic                    pop,
    output logic                    valid,
    output logic [c_DATA_WIDTH-1:0] rd_data,
    output logic [c_LVL_WIDTH-1:0]  level
);
    localparam int c_PW = clog2(c_DEPTH);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(c_DEPTH - 1);

    logic [c_DATA_WIDTH-1:0] mem_q [c_DEPTH];
    logic [c_DATA_WIDTH-1:0] mem_d [c_DEPTH];
    logic [c_PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [c_PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [c_LVL_WIDTH-1:0]  level_q, level_d;
    logic [c_DATA_WIDTH-1:0] hold_q, hold_d;

    function automatic logic [c_PW-1:0] nxt(input logic [c_PW-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    assign valid   = (level_q != '0);
    assign rd_data = valid ? mem_q[rd_ptr_q] : hold_q;
    assign level   = level_q;

    // next-state: write at wr_ptr, pop at rd_ptr, level tracks the difference
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        hold_d   = hold_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = nxt(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = nxt(rd_ptr_q);
        end
        unique case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (valid) begin
            hold_d = mem_q[rd_ptr_q];
        end
    end

    // state registers; reset drops every buffered word
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hold_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hold_q   <= hold_d;
        end
    end

    a_level_bound: assert property (
        @(posedge clk) disable iff (rst)
        level_q <= c_LVL_WIDTH'(c_DEPTH)
    );

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: drains a fixed-latency FIFO read port
// into a valid/ready stream through a small prefetch buffer.
module fifo_rd_stream_adapter
    import fifo_adapter_pkg::*;
#(
    parameter int c_DATA_WIDTH = 32,
    parameter int c_RD_LATENCY = 1,
    parameter int c_LVL_WIDTH  = 2
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst,
    output logic                     fifo_rd_en,
    output logic                     fifo_rd_oce,
    input  logic [c_DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                     fifo_rd_empty,
    fifo_rd_stream_adapter_if.master m,
    output logic [c_LVL_WIDTH-1:0]   buf_level
);
    localparam int c_BUF_DEPTH = buf_depth(c_RD_LATENCY);
    localparam int c_CW        = c_LVL_WIDTH + 2;

    if (c_RD_LATENCY < c_LAT_MIN || c_RD_LATENCY > c_LAT_MAX) begin : g_bad_lat
        $error("c_RD_LATENCY must be 1 or 2");
    end
    if (c_LVL_WIDTH < clog2(c_BUF_DEPTH + 1)) begin : g_bad_lvl
        $error("c_LVL_WIDTH too small for buffer depth");
    end

    logic [c_RD_LATENCY-1:0] sr_q, sr_d;
    logic                    oce_q, oce_d;
    logic [c_CW-1:0]         inflight;
    logic [c_CW-1:0]         demand;
    logic                    rd_en;
    logic                    pop;
    logic                    buf_valid;
    logic [c_DATA_WIDTH-1:0] buf_data;

    // issue only when every outstanding read is guaranteed a buffer slot
    always_comb begin
        pop      = buf_valid && m.m_ready;
        inflight = c_CW'($countones(sr_q));
        demand   = inflight + c_CW'(buf_level) - c_CW'(pop);
        rd_en    = !rd_rst && !fifo_rd_empty
                   && (demand < c_CW'(c_BUF_DEPTH));
        sr_d     = sr_q << 1;
        sr_d[0]  = rd_en;
        oce_d    = 1'b1;
    end

    // in-flight tracker and output-register enable
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            sr_q  <= '0;
            oce_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            oce_q <= oce_d;
        end
    end

    fifo_rd_prefetch_buf #(
        .c_DATA_WIDTH (c_DATA_WIDTH),
        .c_DEPTH      (c_BUF_DEPTH),
        .c_LVL_WIDTH  (c_LVL_WIDTH)
    ) u_buf (
        .clk     (rd_clk),
        .rst     (rd_rst),
        .wr_en   (sr_q[c_RD_LATENCY-1]),
        .wr_data (fifo_rd_data),
        .pop     (pop),
        .valid   (buf_valid),
        .rd_data (buf_data),
        .level   (buf_level)
    );

    assign fifo_rd_en  = rd_en;
    assign fifo_rd_oce = oce_q;
    assign m.m_valid   = buf_valid;
    assign m.m_data    = buf_data;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: directed bench for latency-1 and latency-2
// adapters, each fed by a behavioural FIFO read-port model.
module tb_fifo_rd_stream_adapter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m1 [256];
    logic [31:0] m2 [256];
    int w1 = 0;
    int r1 = 0;
    int w2 = 0;
    int r2 = 0;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    logic [31:0] s2q = '0;
    logic uf1 = 1'b0;
    logic uf2 = 1'b0;
    logic en1, oce1, emp1;
    logic en2, oce2, emp2;
    logic [1:0] lvl1, lvl2;

    assign emp1 = (r1 == w1);
    assign emp2 = (r2 == w2);

    fifo_rd_stream_adapter_if #(.c_DATA_WIDTH(32)) s1 ();
    fifo_rd_stream_adapter_if #(.c_DATA_WIDTH(32)) s2 ();

    fifo_rd_stream_adapter #(
        .c_DATA_WIDTH (32),
        .c_RD_LATENCY (1),
        .c_LVL_WIDTH  (2)
    ) u_l1 (
        .rd_clk        (clk),
        .rd_rst        (rst),
        .fifo_rd_en    (en1),
        .fifo_rd_oce   (oce1),
        .fifo_rd_data  (d1),
        .fifo_rd_empty (emp1),
        .m             (s1),
        .buf_level     (lvl1)
    );

    fifo_rd_stream_adapter #(
        .c_DATA_WIDTH (32),
        .c_RD_LATENCY (2),
        .c_LVL_WIDTH  (2)
    ) u_l2 (
        .rd_clk        (clk),
        .rd_rst        (rst),
        .fifo_rd_en    (en2),
        .fifo_rd_oce   (oce2),
        .fifo_rd_data  (d2),
        .fifo_rd_empty (emp2),
        .m             (s2),
        .buf_level     (lvl2)
    );

    // FIFO read ports: latency 1 (no output reg) and latency 2 (output reg)
    always @(posedge clk) begin
        if (en1) begin
            if (r1 == w1) uf1 <= 1'b1;
            d1 <= m1[r1[7:0]];
            r1 <= r1 + 1;
        end
        if (en2) begin
            if (r2 == w2) uf2 <= 1'b1;
            s2q <= m2[r2[7:0]];
            r2  <= r2 + 1;
        end
        if (oce2) d2 <= s2q;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input int which, input logic [31:0] base,
                        input logic [31:0] step, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 1) begin
                m1[w1[7:0]] = base + step * i;
                w1++;
            end else begin
                m2[w2[7:0]] = base + step * i;
                w2++;
            end
        end
    endtask

    task automatic drain(input logic [31:0] base, input int n,
                         input bit alt, input int budget);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            s2.m_ready = alt ? ~cyc[0] : 1'b1;
            #1;
            if (s2.m_valid && s2.m_ready) begin
                chk("drain_data", s2.m_data, base + got);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("drain_count", got, n);
        s2.m_ready = 1'b0;
    endtask

    task automatic settle();
        s2.m_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("settle_valid", s2.m_valid, 0);
        chk("settle_lvl", lvl2, 0);
        s2.m_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] env;
        logic [31:0] vv;
        logic [31:0] dv [32];
        int lmax;
        int cnt;

        rst = 1'b1;
        s1.m_ready = 1'b0;
        s2.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_en2", en2, 0);
        chk("rst_oce1", oce1, 0);
        chk("rst_oce2", oce2, 0);
        chk("rst_valid2", s2.m_valid, 0);
        chk("rst_data2", s2.m_data, 0);
        chk("rst_lvl2", lvl2, 0);
        rst = 1'b0;

        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (en1 || en2) cnt++;
        end
        chk("empty_rd_en", cnt, 0);
        chk("empty_valid", {s1.m_valid, s2.m_valid}, 0);
        chk("empty_lvl", {lvl1, lvl2}, 0);
        chk("oce_on", {oce1, oce2}, 2'b11);

        s1.m_ready = 1'b1;
        push(1, 32'h11, 32'h11, 3);
        env = '0;
        vv = '0;
        lmax = 0;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            env[k] = en1;
            vv[k] = s1.m_valid;
            dv[k] = s1.m_data;
            if (int'(lvl1) > lmax) lmax = int'(lvl1);
        end
        chk("l1_rd_en", env, 32'h7);
        chk("l1_valid", vv, 32'h1C);
        chk("l1_d0", dv[2], 32'h11);
        chk("l1_d1", dv[3], 32'h22);
        chk("l1_d2", dv[4], 32'h33);
        chk("l1_hold", dv[5], 32'h33);
        chk("l1_lvl_max", lmax, 1);

        s2.m_ready = 1'b1;
        push(2, 32'h200, 32'h1, 16);
        env = '0;
        vv = '0;
        #1;
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clk);
            env[k] = en2;
            vv[k] = s2.m_valid;
            dv[k] = s2.m_data;
        end
        chk("l2_rd_en", env, 32'hFFFF);
        chk("l2_valid", vv, 32'h7FFF8);
        for (int i = 0; i < 16; i++) begin
            chk("l2_data", dv[3+i], 32'h200 + i);
        end

        s2.m_ready = 1'b0;
        push(2, 32'h300, 32'h1, 8);
        env = '0;
        cnt = 0;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            env[k] = en2;
            if (k >= 3 && (!s2.m_valid || s2.m_data !== 32'h300)) cnt++;
        end
        chk("bp_rd_en", env, 32'h7);
        chk("bp_lvl", lvl2, 3);
        chk("bp_hold", cnt, 0);
        drain(32'h300, 8, 1'b0, 40);
        settle();

        push(2, 32'h500, 32'h1, 5);
        repeat (4) @(negedge clk);
        chk("pre_rst_lvl", lvl2, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", s2.m_valid, 0);
        chk("post_rst_lvl", lvl2, 0);
        chk("post_rst_oce", oce2, 0);
        rst = 1'b0;
        drain(32'h503, 2, 1'b0, 20);
        settle();

        push(2, 32'h600, 32'h1, 100);
        drain(32'h600, 100, 1'b1, 500);
        settle();

        chk("no_underflow", {uf1, uf2}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
Read-side consumer for the team's parameterized FIFO. It drains the FIFO read port (rd_en / rd_data / rd_empty) and presents the words as a valid/ready stream. It hides the FIFO's fixed read latency, which is 1 cycle without the output register and 2 cycles with it. It sits between the FIFO read port and any downstream stream sink, in the read clock domain.

Parameters:
- c_DATA_WIDTH, 32: FIFO read data width and stream data width.
- c_RD_LATENCY, 1: cycles from fifo_rd_en to valid fifo_rd_data. Legal values 1 (FIFO output register off) or 2 (register on).
- c_BUF_DEPTH, c_RD_LATENCY+1: prefetch buffer entries. Derived; not overridable.
- c_LVL_WIDTH, 2: width of buf_level. Must hold 0..c_BUF_DEPTH.

Ports:
- rd_clk, in, 1: single clock; all logic is on its rising edge.
- rd_rst, in, 1: synchronous, active-high reset.
- fifo_rd_en, out, 1: read enable to the FIFO; drives both the FIFO read enable and its read clock enable.
- fifo_rd_oce, out, 1: output-register enable to the FIFO.
- fifo_rd_data, in, c_DATA_WIDTH: FIFO read data.
- fifo_rd_empty, in, 1: FIFO empty flag.
- m_valid, out, 1: stream word valid.
- m_ready, in, 1: downstream accepts the word.
- m_data, out, c_DATA_WIDTH: stream word.
- buf_level, out, c_LVL_WIDTH: number of words currently held in the prefetch buffer.

Behaviour:
- Reset (rd_rst=1 at an edge):
  - Outputs: fifo_rd_en=0, fifo_rd_oce=0, m_valid=0, m_data=0, buf_level=0.
  - Internal state: in-flight shift register cleared, buffer read/write pointers cleared.
  - Reset asserted mid-operation discards all in-flight reads and buffered words; no stale word is written after reset.
- fifo_rd_oce: registered; 0 in reset, 1 from the first cycle after reset onward.
- Issue rule (combinational): fifo_rd_en = !rd_rst && !fifo_rd_empty && (inflight + buf_level - pop) < c_BUF_DEPTH.
  - pop = m_valid && m_ready.
  - inflight = number of 1s in a c_RD_LATENCY-bit shift register that captures fifo_rd_en each cycle.
  - A read is never issued while fifo_rd_empty=1. No underflow read reaches the FIFO.
- Return path:
  - The shift-register tap at position c_RD_LATENCY-1 marks a returning read.
  - In that cycle fifo_rd_data is written into the buffer at the write pointer on the closing edge.
- Buffer: c_BUF_DEPTH-entry circular FIFO of registers.
  - Write and read pointers wrap from c_BUF_DEPTH-1 to 0.
  - buf_level updates +1 on write, -1 on pop, and is unchanged when write and pop occur in the same cycle.
- Stream output:
  - m_valid = (buf_level != 0).
  - m_data = buffer entry at the read pointer, held stable while m_valid && !m_ready.
  - m_data does not change while stalled. When m_valid=0, m_data holds its last value.
- Latency: the first word appears on the stream c_RD_LATENCY+1 cycles after the cycle in which fifo_rd_en is first asserted.
- Throughput: with m_ready held at 1 and the FIFO non-empty, fifo_rd_en stays 1 every cycle and m_valid stays 1 every cycle in steady state (100%).
- Backpressure:
  - With m_ready=0, issue stops once inflight + buf_level reaches c_BUF_DEPTH.
  - Buffer overflow is impossible by construction. An assertion checks that buf_level never exceeds c_BUF_DEPTH.
- FIFO goes empty mid-burst: issue stops; in-flight words still land and drain. m_valid falls after the last buffered word is popped.
- Simultaneous write and pop on a full buffer: legal. Level stays at c_BUF_DEPTH and both pointers advance.
- Ordering: words leave in exactly FIFO order; no reordering and no duplication.

Decomposition:
- Shared package fifo_adapter_pkg:
  - Function that computes c_BUF_DEPTH from c_RD_LATENCY.
  - Legal-latency range check constants.
  - clog2 helper for c_LVL_WIDTH.
- One natural sub-module: fifo_rd_prefetch_buf.
  - Contains the circular register buffer with pointers and level.
  - The top level holds the issue logic and the in-flight shift register.

Test Plan:
- c_RD_LATENCY=1; FIFO preloaded with 0x11,0x22,0x33; m_ready=1 → fifo_rd_en high for 3 consecutive cycles; m_valid first rises 2 cycles after the first fifo_rd_en; m_data = 0x11,0x22,0x33 on 3 consecutive cycles; buf_level ≤1.
- c_RD_LATENCY=2; 16 words loaded; m_ready=1 → m_valid continuous for 16 cycles, starting 3 cycles after the first fifo_rd_en; data order matches the write order.
- c_RD_LATENCY=2; 8 words loaded; m_ready=0 → fifo_rd_en pulses exactly 3 times then stays 0; buf_level=3; m_data=word0 held stable. Release m_ready → all 8 words delivered in order.
- FIFO empty throughout → fifo_rd_en never asserts; m_valid=0; buf_level=0.
- rd_rst asserted for 1 cycle while buf_level=2 with 1 read in flight → next cycle: m_valid=0, buf_level=0, fifo_rd_oce=0. The in-flight word is not written into the buffer.
- Alternating m_ready 1/0 with a continuously non-empty FIFO → no word lost or duplicated across 100 words; the overflow assertion never fires.
